// File: rtl/msk_sbox_host.sv
// Masked S-box initiator: encodes a plain byte into a fresh d-share Boolean
// sharing, issues it to the S-box, waits for the result and recombines it.
module msk_sbox_host #(
  parameter int unsigned d     = 2,
  parameter int unsigned TMO   = 64,
  parameter logic [63:0] SEED0 = 64'h0123_4567_89AB_CDEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [63:0]      seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_inverse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             sb_enable,
  output logic             sb_valid_in,
  output logic             sb_inverse,
  output logic [8*d-1:0]   sb_in,
  input  logic [8*d-1:0]   sb_out,
  input  logic             sb_valid_out,
  output logic [1:0]       err
);

  localparam int unsigned SW   = 8 * d;
  localparam int unsigned CW   = $clog2(TMO);
  localparam logic [63:0] POLY = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_HOLD} state_t;

  state_t        state;
  logic [63:0]   lfsr;
  logic [CW-1:0] tmo_cnt;
  logic [SW-1:0] enc_c;
  logic [7:0]    sh0_c;
  logic [7:0]    dec_c;

  // Free-running Galois LFSR supplying mask bits; a zero seed is replaced by SEED0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED0;
    end else if (seed_load) begin
      lfsr <= (seed == 64'd0) ? SEED0 : seed;
    end else begin
      lfsr <= {1'b0, lfsr[63:1]} ^ (lfsr[0] ? POLY : 64'd0);
    end
  end

  // Share encoding: shares 1..d-1 straight from the mask, share 0 completes the XOR
  always_comb begin
    enc_c = '0;
    sh0_c = in_data;
    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned j = 1; j < d; j++) begin
        enc_c[i*d+j] = lfsr[i*(d-1)+j-1];
        sh0_c[i]     = sh0_c[i] ^ lfsr[i*(d-1)+j-1];
      end
      enc_c[i*d] = sh0_c[i];
    end
  end

  // Share recombination of the S-box result
  always_comb begin
    dec_c = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      dec_c[i] = ^sb_out[i*d +: d];
    end
  end

  // Transaction FSM with registered handshake, S-box strobes and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= 8'd0;
      sb_enable   <= 1'b0;
      sb_valid_in <= 1'b0;
      sb_inverse  <= 1'b0;
      sb_in       <= '0;
      err         <= 2'b00;
      tmo_cnt     <= '0;
    end else begin
      sb_valid_in <= 1'b0;
      if (sb_valid_out && (state != S_WAIT)) begin
        err[1] <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            sb_in       <= enc_c;
            sb_inverse  <= in_inverse;
            sb_valid_in <= 1'b1;
            sb_enable   <= 1'b1;
            in_ready    <= 1'b0;
            state       <= S_SEND;
          end
        end
        S_SEND: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (sb_valid_out) begin
            out_data  <= dec_c;
            out_valid <= 1'b1;
            sb_enable <= 1'b0;
            state     <= S_HOLD;
          end else if (tmo_cnt == CW'(TMO - 1)) begin
            err[0]    <= 1'b1;
            sb_enable <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
